// File: rtl/sd_sector_cache.sv
// ---------------------------------------------------------------------------
// sd_sector_cache
//
// Purpose:
//   Single-sector (512-byte) read cache in front of the SD-card SPI sector
//   reader. Byte read requests that hit the buffered sector are answered one
//   cycle after acceptance from an inferred 512x8 block RAM. A miss starts a
//   sector read on the SD reader and captures its 512-byte stream into the
//   buffer. The requested byte is returned once the fill completes. A stalled
//   fill ends with an error response.
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   req_valid/ready     request handshake; req_addr is a byte address
//   rsp_valid           one-cycle pulse qualifying rsp_data / rsp_error
//   flush               invalidate the buffered sector (honoured in S_READY)
//   busy                fill in progress (waiting for SD reader or filling)
//   sd_idle             SD reader can accept a begin_read
//   sd_begin_read       one-cycle start pulse to the SD reader
//   sd_addr             sector (or byte) address for the SD reader
//   sd_byte_valid/byte  received data byte stream from the SD reader
// ---------------------------------------------------------------------------
module sd_sector_cache #(
  parameter int ADDR_W         = 32,
  parameter int BYTE_ADDR_MODE = 0,
  parameter int TIMEOUT_CYCLES = 1048575
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  output logic [7:0]        rsp_data,
  output logic              rsp_error,
  input  logic              flush,
  output logic              busy,
  input  logic              sd_idle,
  output logic              sd_begin_read,
  output logic [31:0]       sd_addr,
  input  logic              sd_byte_valid,
  input  logic [7:0]        sd_byte
);

  localparam int SEC_W = ADDR_W - 9;
  localparam logic [19:0] TIMEOUT_LIMIT = 20'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_READY,
    S_WAIT_IDLE,
    S_FILL,
    S_RESP,
    S_ERR
  } state_t;

  state_t           state_reg, state_next;
  logic             buf_valid_reg, buf_valid_next;
  logic [SEC_W-1:0] tag_reg, tag_next;
  logic [SEC_W-1:0] sector_reg, sector_next;
  logic [8:0]       offset_reg, offset_next;
  logic [9:0]       count_reg, count_next;
  logic [19:0]      timer_reg, timer_next;
  logic [31:0]      sd_addr_reg, sd_addr_next;
  logic             rsp_valid_reg, rsp_valid_next;
  logic             rsp_error_reg, rsp_error_next;

  // Sector buffer: written only during a fill, read with a registered port.
  logic [7:0] mem [512];
  logic [7:0] ram_q;
  logic       ram_we;
  logic       ram_re;
  logic [8:0] ram_waddr;
  logic [8:0] ram_raddr;

  logic             accept;
  logic             hit;
  logic [SEC_W-1:0] req_sector;
  logic [31:0]      sd_addr_calc;

  assign req_sector = req_addr[ADDR_W-1:9];
  assign req_ready  = (state_reg == S_READY);
  assign accept     = req_valid && req_ready;
  assign hit        = buf_valid_reg && (req_sector == tag_reg);

  // SDHC cards take a sector number, SDSC cards a byte address.
  generate
    if (BYTE_ADDR_MODE != 0) begin : g_byte_addr
      assign sd_addr_calc = 32'({req_sector, 9'd0});
    end else begin : g_sector_addr
      assign sd_addr_calc = 32'(req_sector);
    end
  endgenerate

  assign busy          = (state_reg == S_WAIT_IDLE) || (state_reg == S_FILL);
  assign sd_begin_read = (state_reg == S_WAIT_IDLE) && sd_idle;
  assign sd_addr       = sd_addr_reg;
  assign rsp_valid     = rsp_valid_reg;
  assign rsp_error     = rsp_error_reg;
  // RAM output is only meaningful on a good response; zero otherwise.
  assign rsp_data      = (rsp_valid_reg && !rsp_error_reg) ? ram_q : 8'd0;

  always_comb begin
    state_next     = state_reg;
    buf_valid_next = buf_valid_reg;
    tag_next       = tag_reg;
    sector_next    = sector_reg;
    offset_next    = offset_reg;
    count_next     = count_reg;
    timer_next     = timer_reg;
    sd_addr_next   = sd_addr_reg;
    rsp_valid_next = 1'b0;
    rsp_error_next = 1'b0;
    ram_we         = 1'b0;
    ram_waddr      = count_reg[8:0];
    ram_re         = 1'b0;
    ram_raddr      = req_addr[8:0];

    case (state_reg)
      S_READY: begin
        if (accept) begin
          if (hit) begin
            ram_re         = 1'b1;
            rsp_valid_next = 1'b1;
          end else begin
            sector_next    = req_sector;
            offset_next    = req_addr[8:0];
            sd_addr_next   = sd_addr_calc;
            buf_valid_next = 1'b0;
            state_next     = S_WAIT_IDLE;
          end
        end
        // A hit accepted alongside flush was already read above with the
        // old contents; invalidation applies from the next cycle on.
        if (flush) begin
          buf_valid_next = 1'b0;
        end
      end

      S_WAIT_IDLE: begin
        if (sd_idle) begin
          count_next = 10'd0;
          timer_next = 20'd0;
          state_next = S_FILL;
        end
      end

      S_FILL: begin
        if (sd_byte_valid) begin
          ram_we     = 1'b1;
          count_next = count_reg + 10'd1;
          timer_next = 20'd0;
          if (count_reg == 10'd511) begin
            tag_next       = sector_reg;
            buf_valid_next = 1'b1;
            state_next     = S_RESP;
          end
        end else if (timer_reg >= TIMEOUT_LIMIT) begin
          // Error response is registered so it shows during S_ERR.
          rsp_valid_next = 1'b1;
          rsp_error_next = 1'b1;
          state_next     = S_ERR;
        end else if (timer_reg != 20'hFFFFF) begin
          timer_next = timer_reg + 20'd1;
        end
      end

      S_RESP: begin
        ram_re         = 1'b1;
        ram_raddr      = offset_reg;
        rsp_valid_next = 1'b1;
        state_next     = S_READY;
      end

      S_ERR: begin
        buf_valid_next = 1'b0;
        state_next     = S_READY;
      end

      default: begin
        state_next = S_READY;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= S_READY;
      buf_valid_reg <= 1'b0;
      tag_reg       <= '0;
      sector_reg    <= '0;
      offset_reg    <= 9'd0;
      count_reg     <= 10'd0;
      timer_reg     <= 20'd0;
      sd_addr_reg   <= 32'd0;
      rsp_valid_reg <= 1'b0;
      rsp_error_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      buf_valid_reg <= buf_valid_next;
      tag_reg       <= tag_next;
      sector_reg    <= sector_next;
      offset_reg    <= offset_next;
      count_reg     <= count_next;
      timer_reg     <= timer_next;
      sd_addr_reg   <= sd_addr_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_error_reg <= rsp_error_next;
    end
  end

  // Buffer RAM: contents deliberately not reset.
  always_ff @(posedge clock) begin
    if (ram_we && !reset) begin
      mem[ram_waddr] <= sd_byte;
    end
    if (ram_re) begin
      ram_q <= mem[ram_raddr];
    end
  end

endmodule

// File: tb/tb_sd_sector_cache.sv
// ---------------------------------------------------------------------------
// tb_sd_sector_cache
//
// Self-checking bench for sd_sector_cache. Inputs change on the falling
// edge, outputs are sampled on the falling edge (or 1 time unit after an
// input change). A behavioural model holds the cached sector's bytes, the
// valid flag and the cached sector number and decides hit or miss for each
// request.
// ---------------------------------------------------------------------------
module tb_sd_sector_cache;

  localparam int BAM = 0;
  localparam int TO  = 64;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_error;
  logic        flush;
  logic        busy;
  logic        sd_idle;
  logic        sd_begin_read;
  logic [31:0] sd_addr;
  logic        sd_byte_valid;
  logic [7:0]  sd_byte;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model of the cache contents.
  logic [7:0]  model_buf [512];
  bit          model_valid = 1'b0;
  logic [31:0] model_tag   = 32'd0;

  sd_sector_cache #(
    .ADDR_W(32),
    .BYTE_ADDR_MODE(BAM),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr(req_addr),
    .rsp_valid(rsp_valid),
    .rsp_data(rsp_data),
    .rsp_error(rsp_error),
    .flush(flush),
    .busy(busy),
    .sd_idle(sd_idle),
    .sd_begin_read(sd_begin_read),
    .sd_addr(sd_addr),
    .sd_byte_valid(sd_byte_valid),
    .sd_byte(sd_byte)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_sd_addr(input logic [31:0] addr);
    logic [31:0] sector;
    sector = addr / 512;
    return (BAM != 0) ? sector * 512 : sector;
  endfunction

  // Miss sequence. end_mode: 0 = full fill, 1 = stall into timeout,
  // 2 = reset after nbytes. pattern: 0 = i^5A, 1 = i, 2 = random.
  // Starts and ends just after a falling edge.
  task automatic do_miss(input logic [31:0] addr, input int idle_delay,
                         input int nbytes, input int end_mode, input int pattern);
    int          pulses;
    int          pulse_at;
    logic [31:0] got_addr;
    bit          hold_ok;
    bit          fill_ok;
    int          gap;
    int          waited;
    logic [7:0]  v;

    req_valid = 1'b1;
    req_addr  = addr;
    sd_idle   = (idle_delay == 0);
    #1;
    chk("miss_req_ready", req_ready, 1);
    @(negedge clock);
    req_valid   = 1'b0;
    model_valid = 1'b0;
    chk("miss_busy", busy, 1);

    pulses   = 0;
    pulse_at = -1;
    got_addr = 32'd0;
    hold_ok  = 1'b1;
    for (int c = 0; c <= idle_delay; c++) begin
      sd_idle = (c >= idle_delay);
      #1;
      if (sd_begin_read) begin
        pulses++;
        pulse_at = c;
        got_addr = sd_addr;
      end
      if (req_ready || rsp_valid) hold_ok = 1'b0;
      @(negedge clock);
    end
    sd_idle = 1'b0;
    #1;
    chk("begin_one_cycle", sd_begin_read, 0);
    chk("begin_pulses", pulses, 1);
    chk("begin_when_idle", pulse_at, idle_delay);
    chk("sd_addr", got_addr, exp_sd_addr(addr));
    chk("wait_holdoff", hold_ok, 1);

    fill_ok = 1'b1;
    for (int i = 0; i < nbytes; i++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        if (!busy || rsp_valid || req_ready) fill_ok = 1'b0;
        @(negedge clock);
      end
      if (!busy || rsp_valid || req_ready) fill_ok = 1'b0;
      case (pattern)
        0:       v = i[7:0] ^ 8'h5A;
        1:       v = i[7:0];
        default: v = 8'($urandom);
      endcase
      sd_byte_valid = 1'b1;
      sd_byte       = v;
      model_buf[i]  = v;
      @(negedge clock);
      sd_byte_valid = 1'b0;
    end
    chk("fill_quiet", fill_ok, 1);

    if (end_mode == 0) begin
      chk("resp_not_early", rsp_valid, 0);
      @(negedge clock);
      model_valid = 1'b1;
      model_tag   = addr / 512;
      chk("miss_rsp_valid", rsp_valid, 1);
      chk("miss_rsp_data", rsp_data, model_buf[addr % 512]);
      chk("miss_rsp_error", rsp_error, 0);
      chk("miss_busy_fall", busy, 0);
      chk("miss_ready_back", req_ready, 1);
    end else if (end_mode == 1) begin
      waited = 0;
      while (!rsp_valid && waited < 300) begin
        @(negedge clock);
        waited++;
      end
      chk("to_rsp_valid", rsp_valid, 1);
      chk("to_rsp_error", rsp_error, 1);
      chk("to_rsp_data", rsp_data, 0);
      chk("to_window", (waited >= TO && waited <= TO + 2), 1);
      @(negedge clock);
      chk("to_rsp_single", rsp_valid, 0);
      chk("to_ready_back", req_ready, 1);
    end else begin
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("rst_req_ready", req_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_sd_addr", sd_addr, 0);
      chk("rst_begin", sd_begin_read, 0);
      fill_ok = 1'b1;
      for (int i = 0; i < 5; i++) begin
        sd_byte_valid = 1'b1;
        sd_byte       = 8'($urandom);
        @(negedge clock);
        sd_byte_valid = 1'b0;
        if (rsp_valid || busy || !req_ready) fill_ok = 1'b0;
      end
      chk("rst_bytes_ignored", fill_ok, 1);
    end
  endtask

  // Request with hit/miss decided by the model.
  task automatic do_req(input logic [31:0] addr, input int idle_delay);
    if (model_valid && (addr / 512) == model_tag) begin
      req_valid = 1'b1;
      req_addr  = addr;
      #1;
      chk("hit_req_ready", req_ready, 1);
      @(negedge clock);
      req_valid = 1'b0;
      chk("hit_rsp_valid", rsp_valid, 1);
      chk("hit_rsp_data", rsp_data, model_buf[addr % 512]);
      chk("hit_rsp_error", rsp_error, 0);
      chk("hit_no_begin", sd_begin_read, 0);
    end else begin
      do_miss(addr, idle_delay, 512, 0, 2);
    end
  endtask

  logic [31:0] hs_addr [3];
  logic [7:0]  hs_exp  [3];

  initial begin
    reset         = 1'b1;
    req_valid     = 1'b0;
    req_addr      = 32'd0;
    flush         = 1'b0;
    sd_idle       = 1'b1;
    sd_byte_valid = 1'b0;
    sd_byte       = 8'd0;

    repeat (3) @(negedge clock);
    chk("reset_req_ready", req_ready, 1);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_rsp_error", rsp_error, 0);
    chk("reset_busy", busy, 0);
    chk("reset_begin", sd_begin_read, 0);
    chk("reset_sd_addr", sd_addr, 0);
    reset = 1'b0;
    @(negedge clock);

    // Cold miss at address 0, bytes i^5A: response must be 0x5A.
    do_miss(32'h0000_0000, 0, 512, 0, 0);
    chk("cold_data_const", rsp_data, 8'h5A);

    // Back-to-back hits, one accepted per cycle.
    hs_addr[0] = 32'h1FF; hs_exp[0] = 8'hA5;
    hs_addr[1] = 32'h100; hs_exp[1] = 8'h5A;
    hs_addr[2] = 32'h001; hs_exp[2] = 8'h5B;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        chk("stream_rsp_valid", rsp_valid, 1);
        chk("stream_rsp_data", rsp_data, hs_exp[k-1]);
        chk("stream_no_begin", sd_begin_read, 0);
      end
      if (k < 3) begin
        req_valid = 1'b1;
        req_addr  = hs_addr[k];
        #1;
        chk("stream_ready", req_ready, 1);
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clock);
    end
    chk("stream_end_quiet", rsp_valid, 0);

    // Address mode: sector 9, bytes i, offset 0x34.
    do_miss(32'h0000_1234, 0, 512, 0, 1);
    chk("amode_data_const", rsp_data, 8'h34);

    // SD reader busy for 50 cycles after the miss.
    do_miss(32'h0000_4321, 50, 512, 0, 2);

    // Timeout after 100 bytes, then the same address misses again.
    do_miss(32'h0000_8000, 0, 100, 1, 2);
    do_req(32'h0000_8000, 0);

    // Reset after 300 bytes, then the same sector misses.
    do_miss(32'h0000_0600, 3, 300, 2, 2);
    do_req(32'h0000_0600, 0);

    // Flush alone, then a request to the cached sector misses.
    flush = 1'b1;
    @(negedge clock);
    flush       = 1'b0;
    model_valid = 1'b0;
    do_req(32'h0000_0610, 0);

    // Flush together with a hit: hit served with old data, then a miss.
    req_valid = 1'b1;
    req_addr  = 32'h0000_06AB;
    flush     = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
    flush     = 1'b0;
    chk("flush_hit_valid", rsp_valid, 1);
    chk("flush_hit_data", rsp_data, model_buf[9'h0AB]);
    model_valid = 1'b0;
    do_req(32'h0000_06AB, 0);

    // Randomised requests over a few sectors with occasional flushes.
    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 7) == 0) begin
        flush = 1'b1;
        @(negedge clock);
        flush       = 1'b0;
        model_valid = 1'b0;
      end
      do_req((32'($urandom_range(0, 2)) << 9) | 32'($urandom_range(0, 511)),
             $urandom_range(0, 5));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sd_sector_cache.md
Name: sd_sector_cache

Overview:
Single-sector read cache that sits directly downstream of the SD-card SPI sector reader. It takes byte-addressed read requests from the cartridge/ROM loader side. On a miss it starts a 512-byte CMD17 sector read on the SD reader and captures the byte stream into a 512x8 buffer. Requests that hit the buffered sector are then served with one-cycle latency.

Parameters:
ADDR_W, 32, width of req_addr in bytes; sector number = req_addr[ADDR_W-1:9]
BYTE_ADDR_MODE, 0, 0 = sd_addr carries the sector number (SDHC); 1 = sd_addr carries sector<<9 (SDSC)
TIMEOUT_CYCLES, 1048575, max clocks allowed between sd_begin_read and the first byte, and between consecutive bytes

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  read request
req_ready  out  1  block can accept a request this cycle
req_addr  in  ADDR_W  byte address
rsp_valid  out  1  one-cycle pulse; rsp_data/rsp_error valid
rsp_data  out  8  returned byte
rsp_error  out  1  qualifies rsp_valid; fill timed out
flush  in  1  invalidate buffer
busy  out  1  fill in progress
sd_idle  in  1  SD reader idle, can accept begin_read
sd_begin_read  out  1  one-cycle start pulse to the SD reader
sd_addr  out  32  sector address to the SD reader, held stable from the pulse until the fill ends
sd_byte_valid  in  1  one-cycle pulse per received data byte
sd_byte  in  8  data byte, valid when sd_byte_valid=1

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clock.
- Reset values: state=S_READY, buf_valid=0, tag=0, req_ready=1, rsp_valid=0, rsp_data=0, rsp_error=0, busy=0, sd_begin_read=0, sd_addr=0. Buffer RAM contents are not reset.
- Reset asserted mid-fill: all outputs take their reset values the next cycle, buf_valid=0, and the pending request is dropped with no rsp. Remaining SD bytes are ignored because they arrive outside S_FILL.
- Handshake: a request is accepted when req_valid && req_ready. req_ready=1 only in S_READY. req_addr is sampled at accept.
- State S_READY:
  - Hit (buf_valid && sector==tag): RAM read; rsp_valid=1 at accept+1 with rsp_data=buf[addr[8:0]], rsp_error=0. Back-to-back hits are allowed, one per cycle.
  - Miss: latch the sector and offset, go to S_WAIT_IDLE, set buf_valid=0.
- State S_WAIT_IDLE: busy=1. When sd_idle=1, assert sd_begin_read for exactly one cycle and drive sd_addr. sd_addr = sector when BYTE_ADDR_MODE=0, or {sector,9'b0} truncated to 32 bits when BYTE_ADDR_MODE=1. Then go to S_FILL with byte count=0 and the timeout counter cleared.
- State S_FILL: busy=1.
  - Each sd_byte_valid pulse writes sd_byte to buf[count], count+1, and clears the timeout counter.
  - On the write with count==511: tag=sector, buf_valid=1, go to S_RESP.
  - Bytes beyond 512 never occur in S_FILL and are ignored in every other state.
  - Timeout counter reaching TIMEOUT_CYCLES: go to S_ERR.
- State S_RESP: RAM read of the latched offset. Next cycle rsp_valid=1 with the data, then return to S_READY. The miss response comes 2 cycles after the last byte write.
- State S_ERR: one cycle with rsp_valid=1, rsp_error=1, rsp_data=0, buf_valid=0; then S_READY. The SD reader may be left non-idle; the next miss waits in S_WAIT_IDLE.
- flush:
  - In S_READY: clears buf_valid the next cycle. If a hit is accepted in the same cycle, the hit is still served with the old data and flush takes effect afterwards.
  - During a fill: ignored.
- Counters: byte count is 10 bits; timeout counter is 20 bits, saturating.

Test Plan:
- Cold miss: req_addr=0x000, sd_idle=1 → one sd_begin_read pulse with sd_addr=0. Feed 512 bytes b[i]=i[7:0]^0x5A → rsp_valid 2 cycles after the last byte, rsp_data=0x5A, rsp_error=0, busy falling.
- Hit streaming: after the cold miss, requests at 0x1FF, 0x100, 0x001 on consecutive cycles → three rsp pulses at accept+1 with data 0xA5, 0x5A, 0x5B and no sd_begin_read.
- Address modes: miss at req_addr=0x1234 → sd_addr=0x9 with BYTE_ADDR_MODE=0, or 0x1200 with BYTE_ADDR_MODE=1. After fill with b[i]=i, rsp_data=0x34.
- SD busy hold-off: sd_idle=0 for 50 cycles after the miss → sd_begin_read stays 0 and req_ready=0; the pulse occurs in the cycle sd_idle rises.
- Timeout: TIMEOUT_CYCLES=64; stop after 100 bytes → rsp_error=1, rsp_data=0. A re-request of the same address issues a new sd_begin_read.
- Reset and flush:
  - Reset after 300 bytes → no rsp, req_ready=1, and the next request to the same sector misses.
  - flush in S_READY → the next request to the cached sector misses.
